// File: rtl/arbitro_cajero.sv
// Four-terminal round-robin arbiter in front of a single ATM core.
// Grants one terminal at a time, supervises the session (done, blocked
// card, card withdrawn, inactivity) and keeps per-terminal lock flags
// plus a wrapping count of completed sessions.
module arbitro_cajero #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       act_stb,
    input  logic       done,
    input  logic       bloqueo_in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       tarjeta_o,
    output logic       timeout,
    output logic [3:0] lock,
    output logic [7:0] sesiones
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SESSION = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  sel_nx;
    logic [1:0]  ptr;
    logic [1:0]  ptr_nx;
    logic [15:0] timer;
    logic [15:0] timer_nx;
    logic [3:0]  lock_nx;
    logic [7:0]  sesiones_nx;
    logic [3:0]  eligible;
    logic [1:0]  pick;
    logic        found;
    logic [1:0]  idx;

    assign eligible = req & ~lock;

    // Round-robin search: first eligible index starting at ptr, wrapping mod 4.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && eligible[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state logic, session supervision and the inactivity pulse.
    always_comb begin
        state_nx    = state;
        sel_nx      = sel;
        ptr_nx      = ptr;
        timer_nx    = timer;
        lock_nx     = lock;
        sesiones_nx = sesiones;
        timeout     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    sel_nx   = pick;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                timer_nx = TIMEOUT;
                state_nx = SESSION;
            end
            SESSION: begin
                // Release causes in priority order; the blocked card wins so the
                // lock is never lost behind a simultaneous done.
                if (bloqueo_in) begin
                    lock_nx[sel] = 1'b1;
                    state_nx     = RELEASE;
                end else if (done) begin
                    state_nx = RELEASE;
                end else if (!req[sel]) begin
                    state_nx = RELEASE;
                end else if (timer == 16'd0) begin
                    timeout  = 1'b1;
                    state_nx = RELEASE;
                end else if (act_stb) begin
                    timer_nx = TIMEOUT;
                end else begin
                    timer_nx = timer - 16'd1;
                end
            end
            RELEASE: begin
                ptr_nx      = sel + 2'd1;
                sesiones_nx = sesiones + 8'd1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant and card-present are only asserted while a terminal owns the core.
    always_comb begin
        gnt       = 4'b0000;
        tarjeta_o = 1'b0;
        if (state == GRANT || state == SESSION) begin
            gnt[sel]  = 1'b1;
            tarjeta_o = 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 2'd0;
            ptr      <= 2'd0;
            timer    <= 16'd0;
            lock     <= 4'b0000;
            sesiones <= 8'd0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            ptr      <= ptr_nx;
            timer    <= timer_nx;
            lock     <= lock_nx;
            sesiones <= sesiones_nx;
        end
    end

endmodule

// File: tb/tb_arbitro_cajero.sv
// Bench for arbitro_cajero: two instances (TIMEOUT=5 and TIMEOUT=0) share the
// stimulus and are compared every cycle against a behavioural model, plus a
// fixed vector table and directed multi-cycle sequences.
module tb_arbitro_cajero;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req;
    logic       act_stb;
    logic       done;
    logic       bloqueo_in;

    logic [3:0] gnt5, lock5, gnt0, lock0;
    logic [1:0] sel5, sel0;
    logic       tar5, tar0, to5, to0;
    logic [7:0] ses5, ses0;

    arbitro_cajero #(.TIMEOUT(16'd5)) u_dut5 (
        .clk(clk), .rst(rst), .req(req), .act_stb(act_stb), .done(done),
        .bloqueo_in(bloqueo_in), .gnt(gnt5), .sel(sel5), .tarjeta_o(tar5),
        .timeout(to5), .lock(lock5), .sesiones(ses5)
    );

    arbitro_cajero #(.TIMEOUT(16'd0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .act_stb(act_stb), .done(done),
        .bloqueo_in(bloqueo_in), .gnt(gnt0), .sel(sel0), .tarjeta_o(tar0),
        .timeout(to0), .lock(lock0), .sesiones(ses0)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: who holds the core, what phase the hand-off is in, how many
    // cycles have passed since the last activity, and which terminal goes next.
    // Phases: 0 free, 1 grant cycle, 2 in session, 3 release cycle.
    int         to_val[2];
    int         m_phase[2];
    int         m_hold[2];
    int         m_idle[2];
    int         m_next[2];
    int         m_cnt[2];
    logic [3:0] m_lock[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, exp);
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] = 0; m_hold[k] = 0; m_idle[k] = 0;
                m_next[k] = 0; m_cnt[k] = 0; m_lock[k] = 4'b0000;
            end else begin
                case (m_phase[k])
                    0: begin
                        for (int off = 3; off >= 0; off--) begin
                            int t;
                            t = (m_next[k] + off) % 4;
                            if (req[t] && !m_lock[k][t]) begin
                                m_hold[k] = t;
                                m_phase[k] = 1;
                            end
                        end
                    end
                    1: begin
                        m_idle[k] = 0;
                        m_phase[k] = 2;
                    end
                    2: begin
                        if (bloqueo_in) begin
                            m_lock[k][m_hold[k]] = 1'b1;
                            m_phase[k] = 3;
                        end else if (done || !req[m_hold[k]] || m_idle[k] >= to_val[k]) begin
                            m_phase[k] = 3;
                        end else if (act_stb) begin
                            m_idle[k] = 0;
                        end else begin
                            m_idle[k] = m_idle[k] + 1;
                        end
                    end
                    default: begin
                        m_next[k] = (m_hold[k] + 1) % 4;
                        m_cnt[k] = m_cnt[k] + 1;
                        m_phase[k] = 0;
                    end
                endcase
            end
        end
    endtask

    function automatic logic [19:0] model_out(input int k);
        logic [3:0] g;
        logic [1:0] h;
        logic       t, o;
        h = 2'(m_hold[k]);
        g = 4'b0000;
        t = 1'b0;
        if (m_phase[k] == 1 || m_phase[k] == 2) begin
            g[h] = 1'b1;
            t = 1'b1;
        end
        o = (m_phase[k] == 2) && (m_idle[k] >= to_val[k]) && !bloqueo_in && !done && req[h];
        return {g, h, t, o, m_lock[k], 8'(m_cnt[k] % 256)};
    endfunction

    function automatic logic [19:0] dut_out(input int k);
        if (k == 0) return {gnt5, sel5, tar5, to5, lock5, ses5};
        return {gnt0, sel0, tar0, to0, lock0, ses0};
    endfunction

    // One clock: model follows the same edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_t5", 32'(dut_out(0)), 32'(model_out(0)));
        chk("model_t0", 32'(dut_out(1)), 32'(model_out(1)));
    endtask

    task automatic set_in(input logic r, input logic [3:0] q, input logic a,
                          input logic d, input logic b);
        rst = r; req = q; act_stb = a; done = d; bloqueo_in = b;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic       bloq;
        logic [3:0] gnt;
        logic       tar;
        logic [3:0] lock;
        logic [7:0] ses;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int n;
        logic held;
        to_val[0] = 5;
        to_val[1] = 0;
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_hold[k] = 0; m_idle[k] = 0;
            m_next[k] = 0; m_cnt[k] = 0; m_lock[k] = 4'b0000;
        end
        set_in(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Expected TIMEOUT=5 outputs right after each edge.
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'd0};
        tbl[1]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000, 8'd0};
        tbl[2]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000, 8'd0};
        tbl[3]  = '{1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'd0};
        tbl[4]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'd1};
        tbl[5]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 8'd1};
        tbl[6]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 8'd1};
        tbl[7]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'd1};
        tbl[8]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'd2};
        tbl[9]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b0000, 8'd2};
        tbl[10] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b0000, 8'd2};
        tbl[11] = '{1'b0, 4'b1000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 8'd2};
        tbl[12] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 8'd3};
        tbl[13] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 8'd3};
        tbl[14] = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b1000, 8'd3};
        tbl[15] = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b1000, 8'd3};
        tbl[16] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 8'd3};
        tbl[17] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 8'd4};
        tbl[18] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 8'd4};
        tbl[19] = '{1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'd0};
        tbl[20] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b0000, 8'd0};

        for (int i = 0; i < 21; i++) begin
            set_in(tbl[i].rst, tbl[i].req, 1'b0, tbl[i].done, tbl[i].bloq);
            cycle();
            chk($sformatf("vec%0d", i), {15'd0, gnt5, tar5, lock5, ses5},
                {15'd0, tbl[i].gnt, tbl[i].tar, tbl[i].lock, tbl[i].ses});
        end

        // Inactivity timeout on terminal 2 with TIMEOUT=5.
        set_in(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        n = 0;
        while (n < 20 && !to5) begin
            cycle();
            n++;
        end
        chk("timeout_delay", 32'(n), 32'd5);
        cycle();
        chk("timeout_gnt_drop", {28'd0, gnt5}, 32'd0);
        cycle();
        chk("timeout_ses", {24'd0, ses5}, 32'd1);

        // TIMEOUT=0 instance: first session cycle already times out.
        set_in(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("t0_first_cycle_pulse", {31'd0, to0}, 32'd1);
        cycle();
        chk("t0_release", {27'd0, gnt0, tar0}, 32'd0);

        // Activity every 4 cycles keeps the session alive.
        set_in(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            act_stb = (i % 4 == 3);
            cycle();
            if (gnt5 !== 4'b0100 || to5 !== 1'b0) held = 1'b0;
        end
        act_stb = 1'b0;
        chk("activity_held", {31'd0, held}, 32'd1);

        // 256 done-terminated sessions wrap the counter, then reset mid-session.
        set_in(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (n < 1200 && m_cnt[0] < 256) begin
            cycle();
            n++;
        end
        chk("wrap_budget", {31'd0, (m_cnt[0] == 256)}, 32'd1);
        chk("wrap_ses", {24'd0, ses5}, 32'd0);
        done = 1'b0;
        cycle();
        cycle();
        cycle();
        chk("pre_rst_session", {27'd0, gnt5, tar5}, {27'd0, 4'b0001, 1'b1});
        rst = 1'b1;
        cycle();
        chk("mid_rst_outputs", {12'd0, gnt5, sel5, tar5, to5, lock5, ses5}, 32'd0);

        // Random traffic against the model.
        set_in(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            act_stb = ($urandom_range(0, 3) == 0);
            done = ($urandom_range(0, 15) == 0);
            bloqueo_in = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/arbitro_cajero.md
ARBITRO_CAJERO -- requirements
Module: arbitro_cajero

Interface
REQ-001 Parameter TIMEOUT, default 16'd1000, meaning: inactivity cycles allowed in a session before forced release.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high; sampled on rising edge of clk.
REQ-004 req  input  4  per-terminal request; high while a card is inserted at terminal i.
REQ-005 act_stb  input  1  activity strobe from the granted terminal (digit or amount keyed).
REQ-006 done  input  1  single-cycle pulse from the ATM core: transaction finished (balance updated).
REQ-007 bloqueo_in  input  1  single-cycle pulse from the ATM core: card blocked after third wrong PIN.
REQ-008 gnt  output  4  one-hot grant; at most one bit high.
REQ-009 sel  output  2  index of granted terminal, drives ATM core input mux.
REQ-010 tarjeta_o  output  1  card-present to ATM core; high only while a grant is held.
REQ-011 timeout  output  1  single-cycle pulse when a session is forced closed by inactivity.
REQ-012 lock  output  4  per-terminal lock flags; locked terminals are never granted.
REQ-013 sesiones  output  8  count of completed sessions (any release cause), wraps 255->0.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, SESSION, RELEASE; one state register, 2 bits.
REQ-015 Eligible set SHALL be req & ~lock.
REQ-016 IDLE: if eligible set non-zero, SHALL select first eligible index searching ptr, ptr+1, ... mod 4, register it in sel, go to GRANT; else stay IDLE.
REQ-017 GRANT: SHALL last exactly one cycle, load timer with TIMEOUT, go to SESSION.
REQ-018 gnt SHALL equal onehot(sel) and tarjeta_o SHALL be 1 in GRANT and SESSION; both 0 in IDLE and RELEASE.
REQ-019 Grant latency: eligible req sampled in IDLE at edge N -> gnt high from edge N onward (one cycle).
REQ-020 SESSION release causes, priority highest first: bloqueo_in, done, req[sel] low, timer==0.
REQ-021 bloqueo_in in SESSION SHALL set lock[sel] at the same edge the FSM moves to RELEASE.
REQ-022 act_stb in SESSION SHALL reload timer to TIMEOUT; otherwise timer decrements by 1 per cycle.
REQ-023 timer reaching 0 with no higher-priority cause SHALL pulse timeout for one cycle and go to RELEASE.
REQ-024 done, bloqueo_in, act_stb SHALL be ignored outside SESSION.
REQ-025 RELEASE: SHALL last exactly one cycle (guarantees tarjeta_o low >=1 cycle so core returns to its idle state), set ptr = sel+1 mod 4, increment sesiones, go to IDLE.
REQ-026 A terminal whose req stays high after release SHALL not be regranted while another eligible terminal requests (round-robin fairness).
REQ-027 A requester locked mid-request SHALL stay ungranted regardless of req until rst.
REQ-028 TIMEOUT=0 SHALL release on the first SESSION cycle with timeout pulse, unless a higher cause is present.

Reset
REQ-029 rst high at a clock edge SHALL force: state IDLE, gnt 0, sel 0, tarjeta_o 0, timeout 0, lock 0, sesiones 0, ptr 0, timer 0.
REQ-030 rst mid-session SHALL drop gnt and tarjeta_o on that edge with no timeout pulse and no sesiones increment.

Verification
REQ-031 rst; req=4'b0101 held -> gnt=0001 next cycle; done pulse -> RELEASE, then gnt=0100 (ptr=1, skips idle terminal 1), sesiones=1.
REQ-032 TIMEOUT=5, grant terminal 2, no act_stb -> timeout pulse 5 cycles after SESSION entry, gnt=0 next cycle, sesiones incremented.
REQ-033 TIMEOUT=5, act_stb every 4 cycles for 40 cycles -> no timeout, gnt held throughout.
REQ-034 grant terminal 3, bloqueo_in and done same cycle -> lock=1000, release; req[3] kept high -> never regranted until rst.
REQ-035 grant terminal 0, drop req[0] -> tarjeta_o 0 within one cycle, RELEASE then IDLE; sesiones increments.
REQ-036 256 done-terminated sessions -> sesiones wraps to 0; rst asserted mid-session -> all outputs 0 at next edge.
